// File: rtl/snake_pkg.sv
// Shared direction type and helpers for the multi-player snake direction queue.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  function automatic logic is_opposite(dir_t a, dir_t b);
    return (a ^ b) == 2'b11;
  endfunction

  // Button vector bit order is {down, right, left, up}, matching the direction code.
  function automatic dir_t btn_to_dir(logic [3:0] onehot);
    dir_t d;
    d = DIR_UP;
    case (1'b1)
      onehot[1]: d = DIR_LEFT;
      onehot[2]: d = DIR_RIGHT;
      onehot[3]: d = DIR_DOWN;
      default:   d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/snake_dir_chan.sv
// One player channel: button edge detect, turn legality check, pending-turn FIFO
// and the committed direction register.
module snake_dir_chan
  import snake_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [1:0]  INIT_DIR    = 2'b00,
  localparam int unsigned CW         = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    btn,
  input  logic          tick,
  output logic [1:0]    s_dir,
  output logic [CW-1:0] q_count,
  output logic          overflow
);

  localparam int unsigned   PW       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(QUEUE_DEPTH);

  logic [3:0]    prev;
  logic [3:0]    pressed;
  dir_t          fifo [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_last;
  dir_t          cur;
  dir_t          req;
  dir_t          ref_dir;
  logic          single;
  logic          legal;
  logic          pop;
  logic          push;
  logic          drop;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(logic [PW-1:0] p);
    return (p == '0) ? LAST_PTR : p - 1'b1;
  endfunction

  always_comb begin
    pressed   = btn & ~prev;
    single    = (pressed != '0) && ((pressed & (pressed - 4'd1)) == '0);
    req       = btn_to_dir(pressed);
    tail_last = ptr_dec(tail);
    // Compare against the newest queued turn, so chained turns are checked in order.
    ref_dir   = (q_count != '0) ? fifo[tail_last] : cur;
    legal     = single && (req != ref_dir) && !is_opposite(req, ref_dir);
    pop       = tick && (q_count != '0);
    push      = legal && ((q_count != FULL) || pop);
    drop      = legal && (q_count == FULL) && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
      cur      <= dir_t'(INIT_DIR);
      overflow <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        fifo[i] <= DIR_UP;
      end
    end else begin
      prev     <= btn;
      overflow <= drop;
      if (push) begin
        fifo[tail] <= req;
        tail       <= ptr_inc(tail);
      end
      if (pop) begin
        cur  <= fifo[head];
        head <= ptr_inc(head);
      end
      if (push && !pop) begin
        q_count <= q_count + 1'b1;
      end else if (pop && !push) begin
        q_count <= q_count - 1'b1;
      end
    end
  end

  assign s_dir = cur;

endmodule

// File: rtl/snake_dir_queue.sv
// Multi-player buffered snake direction queue: one independent channel per player.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [1:0]  INIT_DIR    = 2'b00,
  localparam int unsigned CW         = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PLAYERS-1:0]    btn_l,
  input  logic [NUM_PLAYERS-1:0]    btn_r,
  input  logic [NUM_PLAYERS-1:0]    btn_u,
  input  logic [NUM_PLAYERS-1:0]    btn_d,
  input  logic                      tick,
  output logic [2*NUM_PLAYERS-1:0]  s_dir,
  output logic [NUM_PLAYERS*CW-1:0] q_count,
  output logic [NUM_PLAYERS-1:0]    overflow
);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_chan
    snake_dir_chan #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .INIT_DIR    (INIT_DIR)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .btn      ({btn_d[g], btn_r[g], btn_l[g], btn_u[g]}),
      .tick     (tick),
      .s_dir    (s_dir[2*g +: 2]),
      .q_count  (q_count[CW*g +: CW]),
      .overflow (overflow[g])
    );
  end

endmodule
